// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer with framing, selectable bit order and a one-word output buffer.
// Optional even-parity bit per word when SERIAL_DESER_PARITY_EN is defined.
module serial_deser #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             serial_i,
  input  logic             bit_valid_i,
  input  logic             frame_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             frame_err_o,
  output logic             overrun_o,
  input  logic             clr_i,
  output logic             parity_err_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef SERIAL_DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic             dir_q;

  logic             start, abort, shift_en, done, dir_sel;
  logic [WIDTH-1:0] sh_base, sh_next, word;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A framed bit always (re)starts a word; the last data or parity bit returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (bit_valid_i) begin
      if (frame_i) begin
        state_d = SHIFT;
      end else if (state_q == SHIFT && cnt_q == LAST) begin
`ifdef SERIAL_DESER_PARITY_EN
        state_d = PARITY;
`else
        state_d = IDLE;
`endif
`ifdef SERIAL_DESER_PARITY_EN
      end else if (state_q == PARITY) begin
        state_d = IDLE;
`endif
      end
    end
  end

  always_comb begin
    busy_o   = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    busy_o   = (state_q != IDLE);
    if (bit_valid_i) begin
      start    = frame_i;
      abort    = frame_i && (state_q != IDLE);
      shift_en = !frame_i && (state_q == SHIFT);
`ifdef SERIAL_DESER_PARITY_EN
      done     = !frame_i && (state_q == PARITY);
`else
      done     = !frame_i && (state_q == SHIFT) && (cnt_q == LAST);
`endif
    end
  end

  // A new word starts from a clean register so stale bits never leak into it.
  always_comb begin
    dir_sel = start ? dir_i : dir_q;
    sh_base = start ? '0 : shreg_q;
    sh_next = dir_sel ? {serial_i, sh_base[WIDTH-1:1]} : {sh_base[WIDTH-2:0], serial_i};
`ifdef SERIAL_DESER_PARITY_EN
    word    = shreg_q;
`else
    word    = sh_next;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      dir_q   <= 1'b0;
    end else if (start) begin
      cnt_q   <= CNT_W'(1);
      shreg_q <= sh_next;
      dir_q   <= dir_i;
    end else if (shift_en) begin
      cnt_q   <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      shreg_q <= sh_next;
    end
  end

  // Output buffer: a completed word is dropped only when the buffer is full and not draining.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= abort;
      if (done && (!valid_o || ready_i)) begin
        data_o  <= word;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (clr_i)                             overrun_o <= 1'b0;
      else if (done && valid_o && !ready_i) overrun_o <= 1'b1;
    end
  end

`ifdef SERIAL_DESER_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          parity_err_o <= 1'b0;
    else if (done && (!valid_o || ready_i)) parity_err_o <= (^shreg_q) ^ serial_i;
  end
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deser.sv
// Self-checking bench for serial_deser: directed cases plus random traffic against a bit-queue model.
module tb_serial_deser;

  localparam int unsigned WIDTH = 8;
`ifdef SERIAL_DESER_PARITY_EN
  localparam int NEED = WIDTH + 1;
`else
  localparam int NEED = WIDTH;
`endif

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             serial_i, bit_valid_i, frame_i, dir_i, ready_i, clr_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o, busy_o, frame_err_o, overrun_o, parity_err_o;

  serial_deser #(.WIDTH(WIDTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .serial_i(serial_i), .bit_valid_i(bit_valid_i),
    .frame_i(frame_i), .dir_i(dir_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .busy_o(busy_o), .frame_err_o(frame_err_o),
    .overrun_o(overrun_o), .clr_i(clr_i), .parity_err_o(parity_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bits of the word in flight, in arrival order.
  int unsigned      bitq[$];
  logic             mdir;
  logic             exp_valid, exp_ovr, exp_perr, exp_ferr;
  logic [WIDTH-1:0] exp_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    bitq.delete();
    mdir      = 1'b0;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    exp_perr  = 1'b0;
    exp_ferr  = 1'b0;
    exp_data  = '0;
  endtask

  task automatic model_step(input logic bv, input logic f, input logic s, input logic d,
                            input logic r, input logic c);
    logic             done;
    logic [WIDTH-1:0] w;
    logic             p;
    done     = 1'b0;
    w        = '0;
    p        = 1'b0;
    exp_ferr = 1'b0;
    if (bv) begin
      if (f) begin
        exp_ferr = (bitq.size() != 0);
        bitq.delete();
        mdir = d;
        bitq.push_back(int'(s));
      end else if (bitq.size() != 0) begin
        bitq.push_back(int'(s));
        if (bitq.size() == NEED) begin
          for (int i = 0; i < int'(WIDTH); i++) begin
            if (mdir) w = w + (WIDTH'(bitq[i]) << i);
            else      w = w + (WIDTH'(bitq[i]) << (int'(WIDTH) - 1 - i));
          end
          for (int i = 0; i < NEED; i++) p = p ^ (bitq[i] != 0);
          done = 1'b1;
          bitq.delete();
        end
      end
    end
    if (done) begin
      if (!exp_valid || r) begin
        exp_data  = w;
        exp_valid = 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
        exp_perr  = p;
`endif
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (exp_valid && r) begin
      exp_valid = 1'b0;
    end
    if (c) exp_ovr = 1'b0;
  endtask

  task automatic check_all();
    check("valid", 32'(valid_o), 32'(exp_valid));
    check("data", 32'(data_o), 32'(exp_data));
    check("busy", 32'(busy_o), 32'(bitq.size() != 0));
    check("frame_err", 32'(frame_err_o), 32'(exp_ferr));
    check("overrun", 32'(overrun_o), 32'(exp_ovr));
    check("parity_err", 32'(parity_err_o), 32'(exp_perr));
  endtask

  task automatic drive(input logic bv, input logic f, input logic s, input logic d,
                       input logic r, input logic c);
    bit_valid_i = bv;
    frame_i     = f;
    serial_i    = s;
    dir_i       = d;
    ready_i     = r;
    clr_i       = c;
    @(posedge clk_i);
    model_step(bv, f, s, d, r, c);
    #1;
    check_all();
  endtask

  // First bit sent is stream[n-1]; it carries frame_i.
  task automatic send_bits(input logic [31:0] stream, input int n, input logic d, input logic r);
    for (int i = 0; i < n; i++) drive(1'b1, i == 0, stream[n-1-i], d, r, 1'b0);
  endtask

  task automatic send_stream(input logic [7:0] stream, input logic d, input logic r);
`ifdef SERIAL_DESER_PARITY_EN
    send_bits({23'd0, stream, ^stream}, 9, d, r);
`else
    send_bits({24'd0, stream}, 8, d, r);
`endif
  endtask

  initial begin
    rst_ni = 1'b0;
    {serial_i, bit_valid_i, frame_i, dir_i, ready_i, clr_i} = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all();
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    rst_ni = 1'b1;

    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("idle_ignore", 32'(busy_o), 32'd0);

    send_stream(8'b1010_0101, 1'b0, 1'b1);
    check("msb_a5_data", 32'(data_o), 32'hA5);
    check("msb_a5_valid", 32'(valid_o), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("msb_a5_consumed", 32'(valid_o), 32'd0);

    send_stream(8'b1010_0101, 1'b1, 1'b1);
    check("lsb_a5_data", 32'(data_o), 32'hA5);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    send_stream(8'b1000_0000, 1'b1, 1'b1);
    check("lsb_01_data", 32'(data_o), 32'h01);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    send_stream(8'h3C, 1'b0, 1'b0);
    send_stream(8'hC3, 1'b0, 1'b0);
    check("bp_data", 32'(data_o), 32'h3C);
    check("bp_overrun", 32'(overrun_o), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_clr", 32'(overrun_o), 32'd0);
    check("bp_hold", 32'(valid_o), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_drain", 32'(valid_o), 32'd0);

    send_bits(32'b1011, 4, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("restart_ferr", 32'(frame_err_o), 32'd1);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, i == 6, 1'b0, 1'b1, 1'b0);
    check("restart_ferr_pulse", 32'(frame_err_o), 32'd0);
`ifdef SERIAL_DESER_PARITY_EN
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    check("restart_data", 32'(data_o), 32'h81);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    send_bits(32'b10110, 5, 1'b0, 1'b1);
    check("midword_busy", 32'(busy_o), 32'd1);
    {serial_i, bit_valid_i, frame_i, dir_i, ready_i, clr_i} = '0;
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("post_rst_valid", 32'(valid_o), 32'd0);
    check("post_rst_busy", 32'(busy_o), 32'd0);
    send_stream(8'h5A, 1'b0, 1'b1);
    check("post_rst_data", 32'(data_o), 32'h5A);
    check("post_rst_vld", 32'(valid_o), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SERIAL_DESER_PARITY_EN
    send_bits(32'h1E1, 9, 1'b0, 1'b1);
    check("par_bad", 32'(parity_err_o), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(32'h1E0, 9, 1'b0, 1'b1);
    check("par_good", 32'(parity_err_o), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, 1'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0);
    end

    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_deser.md
SERIAL_DESER -- requirements
Module: serial_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port serial_i  input  1  serial data bit.
REQ-005 SHALL have port bit_valid_i  input  1  serial_i is sampled this cycle.
REQ-006 SHALL have port frame_i  input  1  qualifies the sampled bit as the first bit of a word.
REQ-007 SHALL have port dir_i  input  1  bit order: 0 = MSB first, 1 = LSB first.
REQ-008 SHALL have port data_o  output  WIDTH  received word.
REQ-009 SHALL have port valid_o  output  1  data_o holds an unconsumed word.
REQ-010 SHALL have port ready_i  input  1  consumer accepts data_o.
REQ-011 SHALL have port busy_o  output  1  a word is partially received.
REQ-012 SHALL have port frame_err_o  output  1  one-cycle pulse when a partial word is aborted.
REQ-013 SHALL have port overrun_o  output  1  sticky: a completed word was dropped.
REQ-014 SHALL have port clr_i  input  1  clears overrun_o.
REQ-015 SHALL have port parity_err_o  output  1  parity status of data_o.

Function
REQ-016 SHALL implement the FSM states IDLE and SHIFT, plus PARITY when SERIAL_DESER_PARITY_EN is defined.
REQ-017 SHALL, in IDLE, ignore any bit with frame_i=0; a bit with frame_i=1 becomes bit 0, latches dir_i for the whole word and moves the FSM to SHIFT.
REQ-018 SHALL, in SHIFT, accept one bit per cycle with bit_valid_i=1 and count received bits modulo WIDTH.
REQ-019 SHALL place the bits as follows: MSB first (dir 0) puts the first bit in data_o[WIDTH-1]; LSB first (dir 1) puts the first bit in data_o[0].
REQ-020 SHALL ignore cycles with bit_valid_i=0 and hold all state during them.
REQ-021 SHALL treat the WIDTH-th bit (or the parity bit when enabled) as completing the word.
REQ-022 SHALL load the completed word into the output register on the same edge that samples its last bit, so valid_o=1 in the following cycle.
REQ-023 SHALL return the FSM to IDLE after word completion.
REQ-024 SHALL keep the shift register separate from the output register, so reception of the next word proceeds while valid_o=1.
REQ-025 SHALL hold valid_o and data_o stable until a cycle with valid_o=1 and ready_i=1, which clears valid_o.
REQ-026 SHALL, when a word completes in the same cycle as a transfer, load the new word and keep valid_o=1, with no overrun.
REQ-027 SHALL, when a word completes while valid_o=1 and ready_i=0, drop the new word, keep the old data_o and set overrun_o.
REQ-028 SHALL, on a bit with frame_i=1 in SHIFT or PARITY, discard the partial word, pulse frame_err_o for one cycle and restart with that bit as bit 0.
REQ-029 SHALL give clr_i priority over a simultaneous overrun set, clearing overrun_o.
REQ-030 SHALL drive busy_o=1 exactly in SHIFT and PARITY.

Reset
REQ-031 SHALL, while rst_ni=0 (asynchronous, active-low), force FSM=IDLE, bit count=0, shift register=0, data_o=0, valid_o=0, busy_o=0, frame_err_o=0, overrun_o=0 and parity_err_o=0.
REQ-032 SHALL, on reset assertion mid-word, discard the partial word and produce no valid_o after reset release.

Configuration
REQ-033 SHALL, when SERIAL_DESER_PARITY_EN is defined, expect one parity bit after the WIDTH data bits (FSM state PARITY) and set parity_err_o with the loaded word when XOR(data bits, parity bit) != 0, i.e. even parity; parity_err_o is valid while valid_o=1.
REQ-034 SHALL, when SERIAL_DESER_PARITY_EN is undefined, have no PARITY state, complete the word after WIDTH bits and tie parity_err_o to 0.

Verification
REQ-035 SHALL cover MSB-first: frame_i with first bit, bits 1,0,1,0,0,1,0,1 on consecutive cycles, ready_i=1 -> data_o=8'hA5 and valid_o=1 the cycle after the 8th bit, valid_o=0 one cycle later.
REQ-036 SHALL cover LSB-first: dir_i=1, same bit stream -> data_o=8'hA5 bit-reversed, i.e. 8'hA5.
REQ-037 SHALL cover LSB-first with bit stream 1,0,0,0,0,0,0,0 -> data_o=8'h01.
REQ-038 SHALL cover back-pressure: ready_i=0, send 8'h3C then 8'hC3 -> data_o stays 8'h3C, overrun_o=1; clr_i for one cycle -> overrun_o=0.
REQ-039 SHALL cover frame restart: 4 bits, then frame_i=1 with a new 8-bit word 8'h81 -> frame_err_o pulses one cycle, data_o=8'h81.
REQ-040 SHALL cover reset mid-word: rst_ni=0 after 5 bits, then release -> valid_o=0 and busy_o=0; a following full word 8'h5A is received correctly.
REQ-041 SHALL cover parity when SERIAL_DESER_PARITY_EN is defined: 8'hF0 with parity bit 1 -> parity_err_o=1; with parity bit 0 -> parity_err_o=0.
